// File: rtl/spi_sram_responder.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : spi_sram_responder
// Description : SPI/QPI serial-SRAM responder with oversampled pins and a
//               byte-addressed internal memory. Optional macro
//               SPI_SRAM_RESP_RDMR_EN adds the RDMR (8'h05) mode-register read.
// Revision    : 1.0
// ============================================================================
module spi_sram_responder #(
  parameter int         SRAM_ADDR_WIDTH = 16,
  parameter int         MEM_ADDR_BITS   = 10,
  parameter int         DUMMY_BYTES     = 1,
  parameter logic [7:0] CMD_READ        = 8'h03,
  parameter logic [7:0] CMD_WRITE       = 8'h02,
  parameter logic [7:0] CMD_EQIO        = 8'h38,
  parameter logic [7:0] CMD_RSTQIO      = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_pin,
  input  logic       sck_pin,
  input  logic [3:0] sio_in,
  output logic [3:0] sio_out,
  output logic [3:0] sio_oe,
  output logic       quad_mode,
  output logic       busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_DUMMY  = 3'd3;
  localparam logic [2:0] S_RDATA  = 3'd4;
  localparam logic [2:0] S_WDATA  = 3'd5;
  localparam logic [2:0] S_IGNORE = 3'd6;
`ifdef SPI_SRAM_RESP_RDMR_EN
  localparam logic [2:0] S_RDMR   = 3'd7;
  localparam logic [7:0] c_CMD_RDMR = 8'h05;
`endif

  localparam int         c_MEM_DEPTH      = 1 << MEM_ADDR_BITS;
  localparam logic [15:0] c_ADDR_LAST_SPI  = 16'(SRAM_ADDR_WIDTH - 1);
  localparam logic [15:0] c_ADDR_LAST_QPI  = 16'(SRAM_ADDR_WIDTH / 4 - 1);
  localparam logic [15:0] c_DUMMY_LAST_SPI = 16'(DUMMY_BYTES * 8 - 1);
  localparam logic [15:0] c_DUMMY_LAST_QPI = 16'(DUMMY_BYTES * 2 - 1);

  logic       r_cs_s1, r_cs_s2, r_cs_d;
  logic       r_sck_s1, r_sck_s2, r_sck_d;
  logic [3:0] r_sio_s1, r_sio_s2;

  logic [2:0]               r_state, w_state_nx;
  logic [15:0]              r_cnt;
  logic [6:0]               r_shift;
  logic [MEM_ADDR_BITS-1:0] r_addr;
  logic                     r_is_read;
  logic                     r_quad;
  logic                     r_wr_en;
  logic [7:0]               r_wr_data;
  logic [7:0]               r_rd_byte;
  logic [7:0]               r_mem [c_MEM_DEPTH];

  logic [3:0] r_sio_out, r_sio_oe, w_out_nx, w_oe_nx;
  logic [7:0] r_tx, w_tx_nx, w_src;
  logic [2:0] r_tx_cnt, w_tx_cnt_nx;

  logic                     w_cs_fall, w_sck_rise, w_sck_fall, w_active;
  logic [7:0]               w_shift_nx;
  logic [MEM_ADDR_BITS-1:0] w_addr_sh_nx, w_fetch_addr;
  logic                     w_byte_last, w_addr_last, w_dummy_last, w_tx_last;
  logic                     w_op_rw, w_op_eqio, w_op_rstqio, w_op_rdmr;
  logic                     w_fetch, w_rd_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_s1  <= 1'b1;
      r_cs_s2  <= 1'b1;
      r_cs_d   <= 1'b1;
      r_sck_s1 <= 1'b0;
      r_sck_s2 <= 1'b0;
      r_sck_d  <= 1'b0;
      r_sio_s1 <= 4'h0;
      r_sio_s2 <= 4'h0;
    end else begin
      r_cs_s1  <= cs_pin;
      r_cs_s2  <= r_cs_s1;
      r_cs_d   <= r_cs_s2;
      r_sck_s1 <= sck_pin;
      r_sck_s2 <= r_sck_s1;
      r_sck_d  <= r_sck_s2;
      r_sio_s1 <= sio_in;
      r_sio_s2 <= r_sio_s1;
    end
  end

  assign w_cs_fall  = r_cs_d & ~r_cs_s2;
  assign w_sck_rise = r_sck_s2 & ~r_sck_d;
  assign w_sck_fall = ~r_sck_s2 & r_sck_d;
  assign w_active   = w_sck_rise & ~r_cs_s2;

  // The address register doubles as the address shifter, so the wire
  // address is masked to MEM_ADDR_BITS as it shifts in.
  assign w_shift_nx   = r_quad ? {r_shift[3:0], r_sio_s2} : {r_shift, r_sio_s2[0]};
  assign w_addr_sh_nx = r_quad ? {r_addr[MEM_ADDR_BITS-5:0], r_sio_s2}
                               : {r_addr[MEM_ADDR_BITS-2:0], r_sio_s2[0]};

  assign w_byte_last  = (r_cnt == (r_quad ? 16'd1 : 16'd7));
  assign w_addr_last  = (r_cnt == (r_quad ? c_ADDR_LAST_QPI : c_ADDR_LAST_SPI));
  assign w_dummy_last = (r_cnt == (r_quad ? c_DUMMY_LAST_QPI : c_DUMMY_LAST_SPI));
  assign w_tx_last    = (r_tx_cnt == (r_quad ? 3'd1 : 3'd7));

  assign w_op_rw     = (w_shift_nx == CMD_READ) | (w_shift_nx == CMD_WRITE);
  assign w_op_eqio   = (w_shift_nx == CMD_EQIO);
  assign w_op_rstqio = (w_shift_nx == CMD_RSTQIO) & r_quad;
`ifdef SPI_SRAM_RESP_RDMR_EN
  assign w_op_rdmr   = (w_shift_nx == c_CMD_RDMR);
  assign w_rd_state  = (r_state == S_RDATA) | (r_state == S_RDMR);
`else
  assign w_op_rdmr   = 1'b0;
  assign w_rd_state  = (r_state == S_RDATA);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (r_cs_s2) begin
      w_state_nx = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_cs_fall) w_state_nx = S_CMD;
        S_CMD: begin
          if (w_sck_rise && w_byte_last) begin
            if (w_op_rw) w_state_nx = S_ADDR;
`ifdef SPI_SRAM_RESP_RDMR_EN
            else if (w_op_rdmr) w_state_nx = S_RDMR;
`endif
            else w_state_nx = S_IGNORE;
          end
        end
        S_ADDR: begin
          if (w_sck_rise && w_addr_last) begin
            if (!r_is_read)            w_state_nx = S_WDATA;
            else if (DUMMY_BYTES == 0) w_state_nx = S_RDATA;
            else                       w_state_nx = S_DUMMY;
          end
        end
        S_DUMMY: if (w_sck_rise && w_dummy_last) w_state_nx = S_RDATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 16'd0;
      r_shift   <= 7'd0;
      r_addr    <= '0;
      r_is_read <= 1'b0;
      r_quad    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_data <= 8'h00;
    end else begin
      r_wr_en <= 1'b0;
      if (w_cs_fall) r_cnt <= 16'd0;
      if (r_wr_en)   r_addr <= r_addr + 1'b1;
      if (w_active) begin
        r_shift <= w_shift_nx[6:0];
        r_cnt   <= r_cnt + 16'd1;
        case (r_state)
          S_CMD: begin
            if (w_byte_last) begin
              r_cnt     <= 16'd0;
              r_is_read <= (w_shift_nx == CMD_READ);
              if (w_op_eqio)        r_quad <= 1'b1;
              else if (w_op_rstqio) r_quad <= 1'b0;
            end
          end
          S_ADDR: begin
            r_addr <= w_addr_sh_nx;
            if (w_addr_last) r_cnt <= 16'd0;
          end
          S_DUMMY: if (w_dummy_last) r_cnt <= 16'd0;
          S_RDATA: begin
            if (w_byte_last) begin
              r_cnt  <= 16'd0;
              r_addr <= r_addr + 1'b1;
            end
          end
          S_WDATA: begin
            if (w_byte_last) begin
              r_cnt     <= 16'd0;
              r_wr_en   <= 1'b1;
              r_wr_data <= w_shift_nx;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Fetch lands one clk after the last rising edge of a byte, well before
  // the next falling edge given the minimum SCK high time.
  assign w_fetch = w_active & (((r_state == S_ADDR) & w_addr_last & r_is_read) |
                               ((r_state == S_RDATA) & w_byte_last));
  assign w_fetch_addr = (r_state == S_ADDR) ? w_addr_sh_nx : r_addr + 1'b1;

  always_ff @(posedge clk) begin
    if (r_wr_en) r_mem[r_addr] <= r_wr_data;
    if (w_fetch) r_rd_byte <= r_mem[w_fetch_addr];
  end

  always_comb begin
    w_src = (r_tx_cnt == 3'd0) ? r_rd_byte : r_tx;
`ifdef SPI_SRAM_RESP_RDMR_EN
    if ((r_state == S_RDMR) && (r_tx_cnt == 3'd0)) w_src = {r_quad, 7'b0};
`endif
    w_out_nx    = r_sio_out;
    w_oe_nx     = r_sio_oe;
    w_tx_nx     = r_tx;
    w_tx_cnt_nx = r_tx_cnt;
    if (r_cs_s2 || !w_rd_state) begin
      w_out_nx    = 4'h0;
      w_oe_nx     = 4'h0;
      w_tx_cnt_nx = 3'd0;
    end else if (w_sck_fall) begin
      w_tx_cnt_nx = w_tx_last ? 3'd0 : r_tx_cnt + 3'd1;
      if (r_quad) begin
        w_out_nx = w_src[7:4];
        w_oe_nx  = 4'hF;
        w_tx_nx  = {w_src[3:0], 4'h0};
      end else begin
        w_out_nx = {2'b00, w_src[7], 1'b0};
        w_oe_nx  = 4'b0010;
        w_tx_nx  = {w_src[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sio_out <= 4'h0;
      r_sio_oe  <= 4'h0;
      r_tx      <= 8'h00;
      r_tx_cnt  <= 3'd0;
    end else begin
      r_sio_out <= w_out_nx;
      r_sio_oe  <= w_oe_nx;
      r_tx      <= w_tx_nx;
      r_tx_cnt  <= w_tx_cnt_nx;
    end
  end

  assign sio_out   = r_sio_out;
  assign sio_oe    = r_sio_oe;
  assign quad_mode = r_quad;
  assign busy      = ~r_cs_s2;

endmodule
`default_nettype wire

// File: tb/tb_spi_sram_responder.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_sram_responder
// Description : Self-checking bench for spi_sram_responder: directed frames
//               plus random write/read traffic against a byte-array model.
// Revision    : 1.0
// ============================================================================
module tb_spi_sram_responder;

  localparam int HALF  = 4;
  localparam int MEMSZ = 1024;
  localparam int DUMMY = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_pin = 1'b1;
  logic       sck_pin = 1'b0;
  logic [3:0] sio_in = 4'h0;
  logic [3:0] sio_out, sio_oe;
  logic       quad_mode, busy;

  spi_sram_responder dut (
    .clk(clk), .rst_n(rst_n), .cs_pin(cs_pin), .sck_pin(sck_pin),
    .sio_in(sio_in), .sio_out(sio_out), .sio_oe(sio_oe),
    .quad_mode(quad_mode), .busy(busy)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] ref_mem   [MEMSZ];
  bit         ref_known [MEMSZ];
  bit         ref_quad = 1'b0;
  logic [3:0] oe_acc;
  logic [7:0] wq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sck_cycle(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
    sio_in = d;
    repeat (HALF) @(negedge clk);
    q  = sio_out;
    oe = sio_oe;
    sck_pin = 1'b1;
    repeat (HALF) @(negedge clk);
    sck_pin = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [3:0] q, oe;
    if (ref_quad) begin
      sck_cycle(b[7:4], q, oe); oe_acc |= oe;
      sck_cycle(b[3:0], q, oe); oe_acc |= oe;
    end else begin
      for (int i = 7; i >= 0; i--) begin
        sck_cycle({3'b000, b[i]}, q, oe);
        oe_acc |= oe;
      end
    end
  endtask

  task automatic recv_byte(output logic [7:0] b, output logic [3:0] oa, output logic [3:0] oo);
    logic [3:0] q, oe;
    b = 8'h00; oa = 4'hF; oo = 4'h0;
    for (int i = 0; i < (ref_quad ? 2 : 8); i++) begin
      sck_cycle(4'h0, q, oe);
      b  = ref_quad ? {b[3:0], q} : {b[6:0], q[1]};
      oa &= oe;
      oo |= oe;
    end
  endtask

  task automatic begin_frame();
    @(negedge clk);
    sck_pin = 1'b0;
    cs_pin  = 1'b0;
    repeat (4) @(negedge clk);
    oe_acc = 4'h0;
  endtask

  task automatic end_frame();
    repeat (2) @(negedge clk);
    cs_pin = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_eqio();
    begin_frame();
    send_byte(8'h38);
    end_frame();
    check("eqio_quad", quad_mode, 1);
    check("eqio_oe", oe_acc, 0);
    ref_quad = 1'b1;
  endtask

  task automatic do_rstqio();
    begin_frame();
    send_byte(8'hFF);
    end_frame();
    check("rstqio_quad", quad_mode, 0);
    ref_quad = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] a);
    begin_frame();
    send_byte(8'h02);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    foreach (wq[i]) begin
      send_byte(wq[i]);
      ref_mem[(int'(a) + i) % MEMSZ]   = wq[i];
      ref_known[(int'(a) + i) % MEMSZ] = 1'b1;
    end
    end_frame();
    check("wr_oe", oe_acc, 0);
  endtask

  task automatic do_read(input logic [15:0] a, input int n, input string tag);
    logic [7:0] b;
    logic [3:0] oa, oo, exp_oe;
    int         idx;
    exp_oe = ref_quad ? 4'hF : 4'h2;
    begin_frame();
    send_byte(8'h03);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    repeat (DUMMY) send_byte(8'h00);
    check({tag, "_oe_hdr"}, oe_acc, 0);
    for (int i = 0; i < n; i++) begin
      recv_byte(b, oa, oo);
      idx = (int'(a) + i) % MEMSZ;
      if (ref_known[idx]) check({tag, "_data"}, b, ref_mem[idx]);
      check({tag, "_oe_data"}, {oa, oo}, {exp_oe, exp_oe});
    end
    end_frame();
    check({tag, "_oe_end"}, sio_oe, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b;
    logic [3:0]  q, oe, oa, oo;
    logic [15:0] a;
    int          len, off;

    repeat (3) @(negedge clk);
    check("rst_sio_out", sio_out, 0);
    check("rst_sio_oe", sio_oe, 0);
    check("rst_quad", quad_mode, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // SPI EQIO with busy observed mid-frame
    begin_frame();
    check("busy_low_cs", busy, 1);
    send_byte(8'h38);
    end_frame();
    check("eqio_quad", quad_mode, 1);
    check("eqio_oe", oe_acc, 0);
    check("busy_idle", busy, 0);
    ref_quad = 1'b1;

    wq = '{8'hC3}; do_write(16'h1236);
    do_read(16'h1236, 1, "c3");
    wq = '{8'hAB, 8'hCD}; do_write(16'h1234);
    do_read(16'h1234, 3, "abcd");
    wq = '{8'h78, 8'h56, 8'h34, 8'h12}; do_write(16'h2000);
    do_read(16'h2001, 2, "mid");
    wq = '{8'hEE, 8'h77}; do_write(16'h03FF);
    do_read(16'h0000, 1, "wrap0");
    do_read(16'h03FF, 2, "wrapr");

    // partial write byte is dropped, completed one kept
    wq = '{8'h5A, 8'h5A}; do_write(16'h0100);
    begin_frame();
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hA5);
    if (ref_quad) sck_cycle(4'h3, q, oe);
    else for (int i = 0; i < 4; i++) sck_cycle(4'h1, q, oe);
    end_frame();
    ref_mem[16'h0100] = 8'hA5;
    do_read(16'h0100, 2, "part");

    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        if (ref_quad) do_rstqio();
        else          do_eqio();
      end
      a   = 16'($urandom);
      len = $urandom_range(1, 4);
      wq.delete();
      for (int i = 0; i < len; i++) wq.push_back(8'($urandom));
      do_write(a);
      off = $urandom_range(0, len - 1);
      do_read(a + 16'(off), len - off, "rnd");
    end

    if (!ref_quad) do_eqio();
`ifdef SPI_SRAM_RESP_RDMR_EN
    begin_frame();
    send_byte(8'h05);
    check("rdmr_q_oe_hdr", oe_acc, 0);
    for (int i = 0; i < 2; i++) begin
      recv_byte(b, oa, oo);
      check("rdmr_q_data", b, 8'h80);
      check("rdmr_q_oe", {oa, oo}, 8'hFF);
    end
    end_frame();
    do_rstqio();
    begin_frame();
    send_byte(8'h05);
    recv_byte(b, oa, oo);
    check("rdmr_s_data", b, 8'h00);
    check("rdmr_s_oe", {oa, oo}, 8'h22);
    end_frame();
`else
    begin_frame();
    send_byte(8'h05);
    repeat (4) send_byte(8'h00);
    end_frame();
    check("op05_no_drive", oe_acc, 0);
    do_rstqio();
    begin_frame();
    send_byte(8'h05);
    repeat (2) send_byte(8'h00);
    end_frame();
    check("op05_spi_no_drive", oe_acc, 0);
`endif

    // reset in the middle of a QPI read
    if (!ref_quad) do_eqio();
    begin_frame();
    send_byte(8'h03); send_byte(8'h12); send_byte(8'h34);
    repeat (DUMMY) send_byte(8'h00);
    recv_byte(b, oa, oo);
    check("prerst_data", b, ref_mem[16'h0234]);
    repeat (3) @(negedge clk);
    check("prerst_oe", sio_oe, 4'hF);
    rst_n = 1'b0;
    #1;
    check("midrst_oe", sio_oe, 0);
    check("midrst_out", sio_out, 0);
    check("midrst_quad", quad_mode, 0);
    cs_pin = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ref_quad = 1'b0;
    repeat (3) @(negedge clk);
    do_read(16'h1234, 2, "postrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
